// File: rtl/asl_pkg.sv
// Shared constants for the ASL layer scheduler: state encoding,
// stage indices and small decode helpers.
package asl_pkg;

   localparam int NUM_STAGES = 6;

   localparam logic [2:0] STG_CAPTURE  = 3'd0;
   localparam logic [2:0] STG_CONV1    = 3'd1;
   localparam logic [2:0] STG_POOL1    = 3'd2;
   localparam logic [2:0] STG_CONV2    = 3'd3;
   localparam logic [2:0] STG_POOL2    = 3'd4;
   localparam logic [2:0] STG_CLASSIFY = 3'd5;
   localparam logic [2:0] STG_NONE     = 3'd7;

   // Stage states are contiguous so stage index = state - 1
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_CAPTURE  = 4'd1;
   localparam logic [3:0] ST_CONV1    = 4'd2;
   localparam logic [3:0] ST_POOL1    = 4'd3;
   localparam logic [3:0] ST_CONV2    = 4'd4;
   localparam logic [3:0] ST_POOL2    = 4'd5;
   localparam logic [3:0] ST_CLASSIFY = 4'd6;
   localparam logic [3:0] ST_DONE     = 4'd7;
   localparam logic [3:0] ST_ERR      = 4'd8;

   function automatic logic in_stage(input logic [3:0] s);
      return (s >= ST_CAPTURE) && (s <= ST_CLASSIFY);
   endfunction

   function automatic logic [2:0] stage_idx(input logic [3:0] s);
      return in_stage(s) ? 3'(s - 4'd1) : STG_NONE;
   endfunction

endpackage

// File: rtl/asl_sched_wdt.sv
// Per-stage watchdog: counts cycles spent in the current stage and
// flags expiry on the last allowed cycle.
module asl_sched_wdt
   import asl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign expired = run && (cnt == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/asl_layer_sched.sv
// ASL layer scheduler: sequences the six CNN stages per camera frame.
// Watchdog/ERR path is built only when ASL_SCHED_WDT_EN is defined.
module asl_layer_sched
   import asl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic       i_clr,
   input  logic [5:0] i_stage_done,
   output logic [5:0] o_stage_start,
   output logic [2:0] o_stage,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_timeout,
   output logic       o_overrun,
   output logic       o_spurious,
   output logic [2:0] o_err_stage
);

   logic [3:0] state;
   logic [3:0] nxt;
   logic [5:0] act_mask;
   logic       act_done;
   logic       set_ovr;
   logic       set_spur;
   logic       wdt_exp;
   logic       entering;

   always_comb begin
      act_mask = in_stage(state) ? (6'd1 << stage_idx(state)) : 6'd0;
      act_done = |(i_stage_done & act_mask);
      set_spur = |(i_stage_done & ~act_mask);
      set_ovr  = i_start && (state != ST_IDLE) && (state != ST_DONE);
      nxt      = state;
      if (i_abort) begin
         nxt = ST_IDLE;
      end else begin
         unique case (1'b1)
            (state == ST_IDLE): begin
               if (i_start) nxt = ST_CAPTURE;
            end
            (state == ST_DONE): begin
               nxt = i_start ? ST_CAPTURE : ST_IDLE;
            end
            (state == ST_ERR): begin
               if (i_clr) nxt = ST_IDLE;
            end
            in_stage(state): begin
               if (act_done) nxt = state + 4'd1;
               else if (wdt_exp) nxt = ST_ERR;
            end
            default: nxt = ST_IDLE;
         endcase
      end
   end

   assign entering = in_stage(nxt) && (nxt != state);

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state         <= ST_IDLE;
         o_stage_start <= '0;
         o_stage       <= STG_NONE;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_overrun     <= 1'b0;
         o_spurious    <= 1'b0;
      end else begin
         state         <= nxt;
         o_stage_start <= entering ? (6'd1 << stage_idx(nxt)) : 6'd0;
         o_stage       <= stage_idx(nxt);
         o_busy        <= in_stage(nxt) || (nxt == ST_ERR);
         o_done        <= (nxt == ST_DONE);
         o_overrun     <= set_ovr || (o_overrun && !i_clr);
         o_spurious    <= set_spur || (o_spurious && !i_clr);
      end
   end

`ifdef ASL_SCHED_WDT_EN
   logic in_stg;
   logic to_fire;

   assign in_stg  = in_stage(state);
   // A done arriving on the expiry cycle takes priority
   assign to_fire = in_stg && !i_abort && !act_done && wdt_exp;

   asl_sched_wdt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdt (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .clear   (entering),
      .run     (in_stg),
      .expired (wdt_exp)
   );

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         o_timeout   <= 1'b0;
         o_err_stage <= 3'd0;
      end else begin
         o_timeout <= to_fire;
         if (to_fire) o_err_stage <= stage_idx(state);
         else if (i_clr) o_err_stage <= 3'd0;
      end
   end
`else
   assign wdt_exp     = 1'b0;
   assign o_timeout   = 1'b0;
   assign o_err_stage = 3'd0;
`endif

endmodule
